// File: rtl/sb_config_loader.sv
// Switch-box configuration loader: accepts write/broadcast/clear commands and
// sequences config_data/config_en into an array of tiles, followed by a settle window.
module sb_config_loader #(
   parameter int unsigned NUM_TILES     = 16,
   parameter int unsigned ADDR_W        = 4,
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic [ADDR_W-1:0]    cmd_addr,
   input  logic [DATA_W-1:0]    cmd_data,
   output logic [DATA_W-1:0]    config_data,
   output logic [NUM_TILES-1:0] config_en,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [15:0]          cfg_count
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_DRIVE = 3'd1;
   localparam logic [2:0] S_SWEEP = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_ERR   = 3'd5;

   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_BCAST = 2'd1;
   localparam logic [1:0] OP_CLEAR = 2'd2;

   localparam int unsigned CNT_W = 4;

   // One extra bit so NUM_TILES == 2^ADDR_W is representable.
   localparam logic [ADDR_W:0]      TILE_LIMIT  = (ADDR_W+1)'(NUM_TILES);
   localparam logic [ADDR_W-1:0]    LAST_TILE   = ADDR_W'(NUM_TILES - 1);
   localparam logic [CNT_W-1:0]     LAST_SETTLE = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [NUM_TILES-1:0] ONE_TILE    = NUM_TILES'(1);

   logic [2:0]           state, state_nxt;
   logic [ADDR_W-1:0]    idx, idx_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [DATA_W-1:0]    config_data_nxt;
   logic [NUM_TILES-1:0] config_en_nxt;
   logic [15:0]          cfg_count_nxt;

   // Next-state and next-output decode; outputs are registered from these values.
   always_comb begin
      state_nxt       = state;
      idx_nxt         = idx;
      cnt_nxt         = cnt;
      config_data_nxt = config_data;
      config_en_nxt   = '0;
      cfg_count_nxt   = cfg_count;
      case (state)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               case (cmd_op)
                  OP_WRITE: begin
                     if ({1'b0, cmd_addr} < TILE_LIMIT) begin
                        state_nxt       = S_DRIVE;
                        config_data_nxt = cmd_data;
                        config_en_nxt   = ONE_TILE << cmd_addr;
                     end else begin
                        state_nxt = S_ERR;
                     end
                  end
                  OP_BCAST: begin
                     state_nxt       = S_DRIVE;
                     config_data_nxt = cmd_data;
                     config_en_nxt   = '1;
                  end
                  OP_CLEAR: begin
                     state_nxt       = S_SWEEP;
                     config_data_nxt = '0;
                     idx_nxt         = '0;
                     config_en_nxt   = ONE_TILE;
                  end
                  default: state_nxt = S_ERR;
               endcase
            end
         end
         S_DRIVE: begin
            state_nxt = S_HOLD;
            cnt_nxt   = '0;
         end
         S_SWEEP: begin
            if (idx == LAST_TILE) begin
               state_nxt = S_HOLD;
               cnt_nxt   = '0;
            end else begin
               idx_nxt       = idx + 1'b1;
               config_en_nxt = ONE_TILE << idx_nxt;
            end
         end
         S_HOLD: begin
            if (cnt == LAST_SETTLE) begin
               state_nxt = S_DONE;
               if (cfg_count != 16'hFFFF) begin
                  cfg_count_nxt = cfg_count + 16'd1;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         S_ERR:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, counters and all registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         idx         <= '0;
         cnt         <= '0;
         config_data <= '0;
         config_en   <= '0;
         cfg_count   <= '0;
         cmd_ready   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         state       <= state_nxt;
         idx         <= idx_nxt;
         cnt         <= cnt_nxt;
         config_data <= config_data_nxt;
         config_en   <= config_en_nxt;
         cfg_count   <= cfg_count_nxt;
         cmd_ready   <= (state_nxt == S_IDLE);
         busy        <= (state_nxt != S_IDLE);
         done        <= (state_nxt == S_DONE);
         err         <= (state_nxt == S_ERR);
      end
   end

endmodule

// File: tb/tb_sb_config_loader.sv
// Directed bench for sb_config_loader: default 16-tile instance plus a 12-tile
// instance for out-of-range addressing.
module tb_sb_config_loader;

   logic        clk;
   logic        reset;

   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [3:0]  cmd_addr;
   logic [31:0] cmd_data;
   logic [31:0] config_data;
   logic [15:0] config_en;
   logic        busy, done, err;
   logic [15:0] cfg_count;

   logic        v12;
   logic        ready12;
   logic [1:0]  op12;
   logic [3:0]  addr12;
   logic [31:0] data12;
   logic [31:0] cdata12;
   logic [11:0] en12;
   logic        busy12, done12, err12;
   logic [15:0] count12;

   int vectors;
   int miscompares;

   sb_config_loader dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .config_data(config_data), .config_en(config_en),
      .busy(busy), .done(done), .err(err), .cfg_count(cfg_count)
   );

   sb_config_loader #(.NUM_TILES(12), .ADDR_W(4), .DATA_W(32), .SETTLE_CYCLES(2)) dut12 (
      .clk(clk), .reset(reset),
      .cmd_valid(v12), .cmd_ready(ready12),
      .cmd_op(op12), .cmd_addr(addr12), .cmd_data(data12),
      .config_data(cdata12), .config_en(en12),
      .busy(busy12), .done(done12), .err(err12), .cfg_count(count12)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Wait for ready, present one command for one cycle; returns in cycle T+1.
   task automatic issue(input bit sel12, input logic [1:0] op, input logic [3:0] addr,
                        input logic [31:0] data);
      int w;
      w = 0;
      while (((sel12 ? ready12 : cmd_ready) !== 1'b1) && w < 50) begin
         step();
         w++;
      end
      if (w >= 50) chk("ready_timeout", 32'd0, 32'd1);
      if (sel12) begin
         v12 = 1'b1; op12 = op; addr12 = addr; data12 = data;
      end else begin
         cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
      end
      step();
      v12 = 1'b0; cmd_valid = 1'b0;
      op12 = 2'd0; addr12 = '0; data12 = '0;
      cmd_op = 2'd0; cmd_addr = '0; cmd_data = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vectors = 0; miscompares = 0;
      reset = 1'b0;
      cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_data = '0;
      v12 = 1'b0; op12 = 2'd0; addr12 = '0; data12 = '0;

      // Reset state
      repeat (3) step();
      chk("rst_ready", 32'(cmd_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_en", 32'(config_en), 32'd0);
      chk("rst_data", config_data, 32'd0);
      chk("rst_count", 32'(cfg_count), 32'd0);
      chk("rst_done_err", {30'd0, done, err}, 32'd0);
      reset = 1'b1;
      step();
      chk("post_rst_ready", 32'(cmd_ready), 32'd1);

      // Single-tile write
      issue(1'b0, 2'd0, 4'd5, 32'hA5A5_0003);
      chk("wr_en_t1", 32'(config_en), 32'h0020);
      chk("wr_data_t1", config_data, 32'hA5A5_0003);
      chk("wr_busy_t1", 32'(busy), 32'd1);
      chk("wr_ready_t1", 32'(cmd_ready), 32'd0);
      step();
      chk("wr_en_t2", 32'(config_en), 32'h0);
      chk("wr_data_t2", config_data, 32'hA5A5_0003);
      step();
      chk("wr_done_t3", 32'(done), 32'd0);
      step();
      chk("wr_done_t4", 32'(done), 32'd1);
      chk("wr_err_t4", 32'(err), 32'd0);
      chk("wr_data_t4", config_data, 32'hA5A5_0003);
      chk("wr_count_t4", 32'(cfg_count), 32'd1);
      step();
      chk("wr_done_t5", 32'(done), 32'd0);
      chk("wr_ready_t5", 32'(cmd_ready), 32'd1);
      chk("wr_busy_t5", 32'(busy), 32'd0);
      chk("wr_data_idle", config_data, 32'hA5A5_0003);

      // Broadcast
      issue(1'b0, 2'd1, 4'd9, 32'h0000_FFFF);
      chk("bc_en_t1", 32'(config_en), 32'hFFFF);
      chk("bc_data_t1", config_data, 32'h0000_FFFF);
      step();
      chk("bc_en_t2", 32'(config_en), 32'h0);
      step();
      step();
      chk("bc_done_t4", 32'(done), 32'd1);
      chk("bc_count_t4", 32'(cfg_count), 32'd2);
      step();
      chk("bc_ready_t5", 32'(cmd_ready), 32'd1);

      // Clear sweep
      issue(1'b0, 2'd2, 4'd0, 32'h0);
      for (int k = 1; k <= 16; k++) begin
         chk("sw_en", 32'(config_en), 32'd1 << (k - 1));
         chk("sw_data", config_data, 32'h0);
         chk("sw_busy", 32'(busy), 32'd1);
         step();
      end
      chk("sw_en_t17", 32'(config_en), 32'h0);
      chk("sw_busy_t17", 32'(busy), 32'd1);
      step();
      chk("sw_done_t18", 32'(done), 32'd0);
      step();
      chk("sw_done_t19", 32'(done), 32'd1);
      chk("sw_busy_t19", 32'(busy), 32'd1);
      chk("sw_count_t19", 32'(cfg_count), 32'd3);
      step();
      chk("sw_busy_t20", 32'(busy), 32'd0);
      chk("sw_ready_t20", 32'(cmd_ready), 32'd1);

      // Reserved opcode
      issue(1'b0, 2'd3, 4'd7, 32'hDEAD_BEEF);
      chk("op3_err_t1", 32'(err), 32'd1);
      chk("op3_done_t1", 32'(done), 32'd0);
      chk("op3_en_t1", 32'(config_en), 32'h0);
      chk("op3_data_t1", config_data, 32'h0);
      chk("op3_count_t1", 32'(cfg_count), 32'd3);
      step();
      chk("op3_err_t2", 32'(err), 32'd0);
      chk("op3_ready_t2", 32'(cmd_ready), 32'd1);

      // Reset during HOLD
      issue(1'b0, 2'd0, 4'd2, 32'h1234_5678);
      chk("mr_en_t1", 32'(config_en), 32'h0004);
      step();
      reset = 1'b0;
      #1;
      chk("mr_en", 32'(config_en), 32'h0);
      chk("mr_data", config_data, 32'h0);
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_count", 32'(cfg_count), 32'd0);
      chk("mr_ready", 32'(cmd_ready), 32'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("mr_no_done", 32'(done), 32'd0);
         chk("mr_ready_held", 32'(cmd_ready), 32'd0);
      end
      reset = 1'b1;
      step();
      chk("mr_ready_after", 32'(cmd_ready), 32'd1);
      chk("mr_done_after", 32'(done), 32'd0);

      // Saturation with cmd_valid held high
      force dut.cfg_count = 16'hFFFE;
      step();
      release dut.cfg_count;
      step();
      chk("sat_preload", 32'(cfg_count), 32'hFFFE);
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = '0; cmd_data = 32'h0000_0001;
      for (int c = 1; c <= 10; c++) begin
         step();
         chk("sat_en", 32'(config_en), (c == 1 || c == 6) ? 32'hFFFF : 32'h0);
         chk("sat_done", 32'(done), (c == 4 || c == 9) ? 32'd1 : 32'd0);
         chk("sat_ready", 32'(cmd_ready), (c == 5 || c == 10) ? 32'd1 : 32'd0);
         if (c >= 4) chk("sat_count", 32'(cfg_count), 32'hFFFF);
      end
      cmd_valid = 1'b0;
      step();
      chk("sat_idle_busy", 32'(busy), 32'd0);
      chk("sat_final_count", 32'(cfg_count), 32'hFFFF);

      // 12-tile instance: out-of-range address, then last valid tile
      issue(1'b1, 2'd0, 4'd13, 32'h5555_AAAA);
      chk("t12_err_t1", 32'(err12), 32'd1);
      chk("t12_en_t1", 32'(en12), 32'h0);
      chk("t12_done_t1", 32'(done12), 32'd0);
      chk("t12_count_t1", 32'(count12), 32'd0);
      step();
      chk("t12_ready_t2", 32'(ready12), 32'd1);
      chk("t12_err_t2", 32'(err12), 32'd0);
      issue(1'b1, 2'd0, 4'd11, 32'hCAFE_0011);
      chk("t12_en_last", 32'(en12), 32'h800);
      chk("t12_data_last", cdata12, 32'hCAFE_0011);
      repeat (3) step();
      chk("t12_done_last", 32'(done12), 32'd1);
      chk("t12_count_last", 32'(count12), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
